// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array drain path.
//   ACCUM_WIDTH_DEF : default width of a partial sum leaving the PE array
//   OUT_WIDTH_DEF   : default width of one scaled output lane
//   drain_state_t   : occupancy state of the drain FSM (IDLE, ALIGN, EMIT)
package systolic_pkg;

    localparam int ACCUM_WIDTH_DEF = 32;
    localparam int OUT_WIDTH_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        EMIT  = 2'd2
    } drain_state_t;

endpackage

// File: rtl/systolic_psum_drain_if.sv
// Valid/ready stream carrying one aligned, scaled vector per beat toward
// the output buffer.
//   out_data  : ROWS lanes of OUT_WIDTH bits, lane r at [r*OUT_WIDTH +: OUT_WIDTH]
//   out_valid : out_data holds a vector
//   out_ready : downstream accepts the vector on this edge
//   out_last  : final vector of the frame
// Modports: master = drain (producer), slave = output buffer (consumer).
interface systolic_psum_drain_if
    import systolic_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) ();

    logic [ROWS*OUT_WIDTH-1:0] out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/psum_row_fifo.sv
// Synchronous FIFO holding the partial sums of one array row.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write request; accepted when not full, or when full and
//                a pop happens on the same edge
//   pop        : read request; ignored when empty
//   wr_data    : value written on an accepted push
//   rd_data    : head entry (valid while !empty)
//   count      : current number of entries
//   full/empty : occupancy flags for the current cycle
//   empty_next : occupancy the FIFO will have after this edge
// DEPTH must be a power of two so the pointers wrap naturally.
module psum_row_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       empty_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;
    logic [CW-1:0]    count_next;

    assign rd_en      = pop && !empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign wr_en      = push && (!full || rd_en);
    assign count_next = count + CW'(wr_en) - CW'(rd_en);
    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign empty_next = (count_next == '0);
    assign rd_data    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count <= count_next;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/systolic_psum_drain.sv
// Drains partial sums from the right-hand column of the systolic array,
// removes the row skew and emits one aligned, scaled vector per beat.
//
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   enable         : array enable; pushes are accepted only while high
//   psum_in        : ROWS partial sums, lane r at [r*ACCUM_WIDTH +: ACCUM_WIDTH]
//   psum_valid_in  : per-lane valid from the PE column
//   out_bus        : master side of the output stream (data/valid/ready/last)
//   almost_full    : some row FIFO holds >= FIFO_DEPTH-ROWS entries
//   overflow_err   : sticky, a push was lost to a full FIFO
//   skew_err       : sticky, rows stayed misaligned for SKEW_TIMEOUT cycles
//   clear_err      : synchronous clear of both sticky flags
//
// Build option
//   PSUM_DRAIN_SATURATE_EN : clamp each scaled lane to the signed OUT_WIDTH
//                            range; when undefined the lane wraps instead.
//
// FSM (state follows FIFO occupancy after each edge)
//   state | meaning
//   IDLE  | every row FIFO empty
//   ALIGN | some rows hold data, others are still empty; skew timer running
//   EMIT  | every row FIFO holds data; vectors pop whenever the output allows
module systolic_psum_drain
    import systolic_pkg::*;
#(
    parameter int ROWS          = 4,
    parameter int ACCUM_WIDTH   = ACCUM_WIDTH_DEF,
    parameter int OUT_WIDTH     = OUT_WIDTH_DEF,
    parameter int SHIFT         = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int SKEW_TIMEOUT  = 8,
    parameter int VEC_PER_FRAME = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [ROWS*ACCUM_WIDTH-1:0] psum_in,
    input  logic [ROWS-1:0]             psum_valid_in,
    systolic_psum_drain_if.master       out_bus,
    output logic                        almost_full,
    output logic                        overflow_err,
    output logic                        skew_err,
    input  logic                        clear_err
);

    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int TW = $clog2(SKEW_TIMEOUT+1);
    localparam int FW = (VEC_PER_FRAME > 1) ? $clog2(VEC_PER_FRAME) : 1;

    drain_state_t               state;
    drain_state_t               state_next;
    logic [ROWS-1:0]            push;
    logic [ROWS-1:0]            fifo_full;
    logic [ROWS-1:0]            fifo_empty;
    logic [ROWS-1:0]            fifo_empty_next;
    logic [ACCUM_WIDTH-1:0]     fifo_rd [ROWS];
    logic [CW-1:0]              fifo_count [ROWS];
    logic                       pop;
    logic                       handshake;
    logic                       ovf_hit;
    logic                       skew_hit;
    logic [TW-1:0]              skew_timer;
    logic [TW-1:0]              skew_timer_next;
    logic [FW-1:0]              frame_cnt;
    logic [ROWS*OUT_WIDTH-1:0]  scaled;
    logic [ROWS*OUT_WIDTH-1:0]  out_data_q;
    logic                       out_valid_q;

    // The PE holds its outputs while disabled; taking them would replay data.
    assign push      = enable ? psum_valid_in : '0;
    assign pop       = (fifo_empty == '0) && (!out_valid_q || out_bus.out_ready);
    assign handshake = out_valid_q && out_bus.out_ready;
    assign ovf_hit   = (|(push & fifo_full)) && !pop;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        psum_row_fifo #(
            .WIDTH (ACCUM_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push       (push[r]),
            .pop        (pop),
            .wr_data    (psum_in[r*ACCUM_WIDTH +: ACCUM_WIDTH]),
            .rd_data    (fifo_rd[r]),
            .count      (fifo_count[r]),
            .full       (fifo_full[r]),
            .empty      (fifo_empty[r]),
            .empty_next (fifo_empty_next[r])
        );
    end

    always_comb begin
        almost_full = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (fifo_count[r] >= CW'(FIFO_DEPTH - ROWS)) almost_full = 1'b1;
        end
    end

    // Scaling: arithmetic shift, then narrow each lane to OUT_WIDTH.
`ifdef PSUM_DRAIN_SATURATE_EN
    localparam logic signed [ACCUM_WIDTH-1:0] SAT_MAX =
        ACCUM_WIDTH'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
    localparam logic signed [ACCUM_WIDTH-1:0] SAT_MIN =
        ACCUM_WIDTH'(-(64'sd1 <<< (OUT_WIDTH-1)));

    logic signed [ACCUM_WIDTH-1:0] shifted [ROWS];

    always_comb begin
        scaled = '0;
        for (int r = 0; r < ROWS; r++) begin
            shifted[r] = $signed(fifo_rd[r]) >>> SHIFT;
            if (shifted[r] > SAT_MAX)
                scaled[r*OUT_WIDTH +: OUT_WIDTH] = SAT_MAX[OUT_WIDTH-1:0];
            else if (shifted[r] < SAT_MIN)
                scaled[r*OUT_WIDTH +: OUT_WIDTH] = SAT_MIN[OUT_WIDTH-1:0];
            else
                scaled[r*OUT_WIDTH +: OUT_WIDTH] = shifted[r][OUT_WIDTH-1:0];
        end
    end
`else
    always_comb begin
        scaled = '0;
        for (int r = 0; r < ROWS; r++) begin
            scaled[r*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'($signed(fifo_rd[r]) >>> SHIFT);
        end
    end
`endif

    // Next state follows the occupancy the FIFOs will have after this edge.
    // The skew timer counts down the ALIGN cycles left before skew_err; the
    // FSM never drops data on timeout, it only flags it.
    always_comb begin
        state_next      = state;
        skew_timer_next = '0;
        skew_hit        = 1'b0;

        if (&fifo_empty_next)
            state_next = IDLE;
        else if (fifo_empty_next == '0)
            state_next = EMIT;
        else
            state_next = ALIGN;

        if (state_next == ALIGN) begin
            if (state != ALIGN)
                skew_timer_next = TW'(SKEW_TIMEOUT - 1);
            else if (skew_timer != '0)
                skew_timer_next = skew_timer - 1'b1;
            else
                skew_timer_next = '0;
            skew_hit = (skew_timer_next == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            skew_timer <= '0;
        end else begin
            state      <= state_next;
            skew_timer <= skew_timer_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            if (pop) begin
                out_data_q  <= scaled;
                out_valid_q <= 1'b1;
            end else if (out_bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (handshake) begin
                if (frame_cnt == FW'(VEC_PER_FRAME - 1))
                    frame_cnt <= '0;
                else
                    frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // A fault arriving in the same cycle as clear_err keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_err <= 1'b0;
            skew_err     <= 1'b0;
        end else begin
            overflow_err <= (overflow_err && !clear_err) || ovf_hit;
            skew_err     <= (skew_err && !clear_err) || skew_hit;
        end
    end

    assign out_bus.out_data  = out_data_q;
    assign out_bus.out_valid = out_valid_q;
    assign out_bus.out_last  = out_valid_q && (frame_cnt == FW'(VEC_PER_FRAME - 1));

endmodule
